// File: rtl/cpu_isa_pkg.sv
// Shared ISA definitions for the 16-bit single-cycle CPU: opcodes, the halt word
// and the fetch sequencer state encoding.
package cpu_isa_pkg;

  localparam logic [3:0]  OP_LB     = 4'b0010;
  localparam logic [3:0]  OP_SB     = 4'b0100;
  localparam logic [3:0]  OP_ADDI   = 4'b0101;
  localparam logic [3:0]  OP_ANDI   = 4'b0110;
  localparam logic [3:0]  OP_BNE    = 4'b1001;
  localparam logic [3:0]  OP_BGEZ   = 4'b1010;
  localparam logic [3:0]  OP_BLTZ   = 4'b1011;
  localparam logic [3:0]  OP_RTYPE  = 4'b1111;

  localparam logic [15:0] HALT_WORD = 16'h0000;

  typedef enum logic [1:0] {
    FS_BOOT = 2'd0,
    FS_RUN  = 2'd1,
    FS_HALT = 2'd2
  } fetch_state_e;

  function automatic logic is_branch(input logic [3:0] op);
    return (op == OP_BNE) || (op == OP_BGEZ) || (op == OP_BLTZ);
  endfunction

endpackage

// File: rtl/branch_target_gen.sv
// PC-relative branch target: addr + (sext(imm6) << 1), wrapping modulo 2^ADDR_W.
module branch_target_gen #(
  parameter int ADDR_W = 8
) (
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [5:0]        i_imm6,
  output logic [ADDR_W-1:0] o_target
);

  logic [ADDR_W-1:0] w_off;

  always_comb begin
    w_off    = ADDR_W'($signed(i_imm6)) << 1;
    o_target = i_addr + w_off;
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and fetch sequencer: BOOT settle delay, sequential/branch PC
// update, halt-word detection and a saturating retired-instruction counter.
module pc_fetch_unit
  import cpu_isa_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int INSN_W      = 16,
  parameter int BOOT_CYCLES = 2,
  parameter int CNT_W       = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [INSN_W-1:0] INSN,
  input  logic              BR_TAKEN,
  input  logic              STALL,
  input  logic              RESUME,
  output logic [ADDR_W-1:0] ADDR,
  output logic              INSN_VALID,
  output logic              HALTED,
  output logic [CNT_W-1:0]  RETIRED
);

  localparam int BW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;

  fetch_state_e      r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [CNT_W-1:0]  r_retired, w_retired_nxt;
  logic [BW-1:0]     r_boot_cnt, w_boot_cnt_nxt;
  logic              r_halted, w_halted_nxt;

  logic [ADDR_W-1:0] w_target;
  logic              w_is_halt;
  logic              w_take;

  branch_target_gen #(.ADDR_W(ADDR_W)) u_btg (
    .i_addr   (r_addr),
    .i_imm6   (INSN[5:0]),
    .o_target (w_target)
  );

  assign w_is_halt = (INSN == INSN_W'(HALT_WORD));
  assign w_take    = is_branch(INSN[15:12]) && BR_TAKEN;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state    <= FS_BOOT;
      r_addr     <= '0;
      r_retired  <= '0;
      r_boot_cnt <= '0;
      r_halted   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_addr     <= w_addr_nxt;
      r_retired  <= w_retired_nxt;
      r_boot_cnt <= w_boot_cnt_nxt;
      r_halted   <= w_halted_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_addr_nxt     = r_addr;
    w_retired_nxt  = r_retired;
    w_boot_cnt_nxt = r_boot_cnt;
    w_halted_nxt   = r_halted;
    INSN_VALID     = 1'b0;

    unique case (r_state)
      FS_BOOT: begin
        w_addr_nxt     = '0;
        w_boot_cnt_nxt = r_boot_cnt + 1'b1;
        if (r_boot_cnt == BW'(BOOT_CYCLES - 1)) w_state_nxt = FS_RUN;
      end
      FS_RUN: begin
        INSN_VALID = !STALL && !w_is_halt;
        // Stall is checked first so a stalled halt word does not halt the core.
        if (!STALL) begin
          if (w_is_halt) begin
            w_state_nxt  = FS_HALT;
            w_halted_nxt = 1'b1;
          end else begin
            w_addr_nxt = w_take ? w_target : r_addr + ADDR_W'(2);
            if (r_retired != '1) w_retired_nxt = r_retired + 1'b1;
          end
        end
      end
      FS_HALT: begin
        if (RESUME) begin
          w_state_nxt  = FS_RUN;
          w_addr_nxt   = '0;
          w_halted_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt = FS_BOOT;
      end
    endcase
  end

  assign ADDR    = r_addr;
  assign HALTED  = r_halted;
  assign RETIRED = r_retired;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: walks a small program through boot, branches,
// stall, halt/resume, wrap and mid-cycle reset; a CNT_W=4 instance checks saturation.
module tb_pc_fetch_unit;

  localparam logic [15:0] W_ADDI = 16'h5001;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        br_taken, stall, resume;
  logic [15:0] insn;
  logic [7:0]  addr;
  logic        insn_valid, halted;
  logic [15:0] retired;

  logic [7:0]  addr2;
  logic        insn_valid2, halted2;
  logic [3:0]  retired2;

  logic [15:0] mem [128];

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  always #5 clk = ~clk;

  assign insn = mem[addr[7:1]];

  pc_fetch_unit #(.ADDR_W(8), .INSN_W(16), .BOOT_CYCLES(2), .CNT_W(16)) dut (
    .CLK        (clk),
    .RESET      (rst_n),
    .INSN       (insn),
    .BR_TAKEN   (br_taken),
    .STALL      (stall),
    .RESUME     (resume),
    .ADDR       (addr),
    .INSN_VALID (insn_valid),
    .HALTED     (halted),
    .RETIRED    (retired)
  );

  pc_fetch_unit #(.ADDR_W(8), .INSN_W(16), .BOOT_CYCLES(2), .CNT_W(4)) dut_sat (
    .CLK        (clk),
    .RESET      (rst_n),
    .INSN       (W_ADDI),
    .BR_TAKEN   (1'b0),
    .STALL      (1'b0),
    .RESUME     (1'b0),
    .ADDR       (addr2),
    .INSN_VALID (insn_valid2),
    .HALTED     (halted2),
    .RETIRED    (retired2)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_addr(input logic [7:0] target, input int unsigned budget);
    for (int unsigned n = 0; n < budget && addr !== target; n++) tick();
    check_eq("wait_addr", {24'h0, addr}, {24'h0, target});
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = W_ADDI;
    mem[8'h22 >> 1] = 16'b1001000111111000;  // BNE imm -8
    mem[8'h3E >> 1] = 16'b1010100000010111;  // BGEZ imm +23
    mem[8'h84 >> 1] = 16'h0000;              // halt word

    rst_n = 1'b0; br_taken = 1'b0; stall = 1'b0; resume = 1'b0;
    tick();
    tick();
    check_eq("rst_addr",    {24'h0, addr}, 32'h0);
    check_eq("rst_retired", {16'h0, retired}, 32'h0);
    check_eq("rst_halted",  {31'h0, halted}, 32'h0);
    check_eq("rst_valid",   {31'h0, insn_valid}, 32'h0);
    rst_n = 1'b1;

    // boot: two cycles with ADDR=0 and no valid
    check_eq("boot1_valid", {31'h0, insn_valid}, 32'h0);
    tick();
    check_eq("boot2_valid", {31'h0, insn_valid}, 32'h0);
    check_eq("boot2_addr",  {24'h0, addr}, 32'h0);
    tick();
    check_eq("run_valid",   {31'h0, insn_valid}, 32'h1);
    check_eq("run_addr0",   {24'h0, addr}, 32'h00);
    tick();
    check_eq("run_addr2",   {24'h0, addr}, 32'h02);
    tick();
    check_eq("run_addr4",   {24'h0, addr}, 32'h04);
    tick();
    check_eq("ret_after3",  {16'h0, retired}, 32'd3);
    tick();
    check_eq("addr8",       {24'h0, addr}, 32'h08);

    // stall for three cycles at 0x08
    stall = 1'b1;
    #1;
    check_eq("stall_valid", {31'h0, insn_valid}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("stall_addr", {24'h0, addr}, 32'h08);
      check_eq("stall_ret",  {16'h0, retired}, 32'd4);
    end
    stall = 1'b0;

    // non-branch with BR_TAKEN=1 steps sequentially
    br_taken = 1'b1;
    wait_addr(8'h10, 20);
    tick();
    check_eq("addi_br_ignored", {24'h0, addr}, 32'h12);

    wait_addr(8'h22, 20);
    check_eq("ret_at_22a", {16'h0, retired}, 32'd17);
    tick();
    check_eq("bne_taken", {24'h0, addr}, 32'h12);
    wait_addr(8'h22, 20);
    check_eq("ret_at_22b", {16'h0, retired}, 32'd26);
    br_taken = 1'b0;
    tick();
    check_eq("bne_not_taken", {24'h0, addr}, 32'h24);
    check_eq("ret_at_24",     {16'h0, retired}, 32'd27);

    br_taken = 1'b1;
    wait_addr(8'h3E, 20);
    check_eq("ret_at_3e", {16'h0, retired}, 32'd40);
    tick();
    check_eq("bgez_taken", {24'h0, addr}, 32'h6C);

    wait_addr(8'h84, 20);
    check_eq("halt_word_valid", {31'h0, insn_valid}, 32'h0);
    check_eq("ret_at_84",       {16'h0, retired}, 32'd53);
    tick();
    check_eq("halted",        {31'h0, halted}, 32'h1);
    check_eq("halt_addr",     {24'h0, addr}, 32'h84);
    check_eq("halt_ret",      {16'h0, retired}, 32'd53);
    check_eq("halt_valid",    {31'h0, insn_valid}, 32'h0);
    tick();
    check_eq("halt_hold",     {24'h0, addr}, 32'h84);

    // RESUME wins over STALL in HALT
    stall = 1'b1; resume = 1'b1;
    tick();
    stall = 1'b0; resume = 1'b0;
    check_eq("resume_addr",   {24'h0, addr}, 32'h00);
    check_eq("resume_halted", {31'h0, halted}, 32'h0);
    check_eq("resume_ret",    {16'h0, retired}, 32'd53);

    // stalled halt word does not halt until STALL drops
    mem[1] = 16'h0000;
    br_taken = 1'b0;
    tick();
    check_eq("addr2_again", {24'h0, addr}, 32'h02);
    stall = 1'b1;
    tick();
    tick();
    check_eq("stall_halt_halted", {31'h0, halted}, 32'h0);
    check_eq("stall_halt_addr",   {24'h0, addr}, 32'h02);
    stall = 1'b0;
    tick();
    check_eq("late_halted", {31'h0, halted}, 32'h1);
    check_eq("late_ret",    {16'h0, retired}, 32'd54);

    mem[1] = W_ADDI;
    mem[8'h84 >> 1] = W_ADDI;
    resume = 1'b1;
    tick();
    resume = 1'b0;

    // sequential wrap at 0xFE
    wait_addr(8'hFE, 200);
    check_eq("ret_at_fe", {16'h0, retired}, 32'd181);
    tick();
    check_eq("wrap_addr", {24'h0, addr}, 32'h00);
    check_eq("wrap_ret",  {16'h0, retired}, 32'd182);

    // self-loop branch (imm6=0, taken)
    mem[3] = 16'h9000;
    br_taken = 1'b1;
    wait_addr(8'h06, 10);
    tick();
    check_eq("selfloop_addr", {24'h0, addr}, 32'h06);
    check_eq("selfloop_ret",  {16'h0, retired}, 32'd186);
    check_eq("addr_lsb",      {31'h0, addr[0]}, 32'h0);

    // saturating counter instance has seen far more than 15 commits
    check_eq("sat_retired", {28'h0, retired2}, 32'hF);
    check_eq("sat_valid",   {31'h0, insn_valid2}, 32'h1);
    check_eq("sat_halted",  {31'h0, halted2}, 32'h0);
    check_eq("sat_addr_lsb", {31'h0, addr2[0]}, 32'h0);

    // asynchronous reset mid-cycle
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_addr",    {24'h0, addr}, 32'h0);
    check_eq("async_ret",     {16'h0, retired}, 32'h0);
    check_eq("async_valid",   {31'h0, insn_valid}, 32'h0);
    check_eq("async_sat_ret", {28'h0, retired2}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
